// File: rtl/comp_rr_arbiter_if.sv
// Requester-side bundle of the round-robin comparator arbiter.
// The arbiter uses the slave modport; the requesters use the master modport.
interface comp_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           done;
    logic           c;
    logic           agb;
    logic           alb;
    logic           busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, c, agb, alb, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, c, agb, alb, busy
    );
endinterface

// File: rtl/comp_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among N requesters.
// Each grant runs IDLE -> CMP -> RESP; the last winner is masked for one IDLE cycle.
module comp_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input logic              clk,
    input logic              rst,
    comp_rr_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           done_q, done_d;
    logic           c_q, c_d;
    logic           agb_q, agb_d;
    logic           alb_q, alb_d;

    logic [N-1:0]   req_m;
    logic           found;
    logic [PW-1:0]  pick;
    logic [N-1:0]   pick_oh;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           eq;
    logic           gt;

    // The single shared comparator, fed only by the captured operands.
    assign eq = (a_q == b_q);
    assign gt = (a_q > b_q);

    // Round-robin: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        req_m   = bus.req & ~mask_q;
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_m[i] && (PW'(i) >= ptr_q)) begin
                found = 1'b1;
                pick  = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_m[i]) begin
                found = 1'b1;
                pick  = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pick == PW'(i)) begin
                pick_oh[i] = 1'b1;
                a_sel      = bus.a_in[i*W +: W];
                b_sel      = bus.b_in[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = done_q;
        c_d     = c_q;
        agb_d   = agb_q;
        alb_d   = alb_q;
        unique case (state_q)
            IDLE: begin
                mask_d = '0;
                if (found) begin
                    gnt_d   = pick_oh;
                    win_d   = pick;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    state_d = CMP;
                end
            end
            CMP: begin
                c_d     = eq;
                agb_d   = gt;
                alb_d   = !eq && !gt;
                done_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                done_d  = 1'b0;
                gnt_d   = '0;
                mask_d  = gnt_q;
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            c_q     <= 1'b0;
            agb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            c_q     <= c_d;
            agb_q   <= agb_d;
            alb_q   <= alb_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;
    assign bus.agb  = agb_q;
    assign bus.alb  = alb_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_comp_rr_arbiter.sv
// Directed bench for comp_rr_arbiter: a per-cycle vector table plus
// hand-written round-robin and reset-abort sequences.
module tb_comp_rr_arbiter;
    logic clk;
    logic rst;

    comp_rr_arbiter_if #(.N(4), .W(4)) bif ();

    comp_rr_arbiter #(.N(4), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {gnt[3:0], done, c, agb, alb, busy}
    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [8:0]  exp;
    } vec_t;

    vec_t vt [24];
    int   n_vec;
    int   n_bad;

    function automatic logic [8:0] outs();
        return {bif.gnt, bif.done, bif.c, bif.agb, bif.alb, bif.busy};
    endfunction

    task automatic chk(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = outs();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gnt/done/c/agb/alb/busy=%b want %b",
                     nm, act, exp);
        end
    endtask

    initial begin
        logic [2:0]  res [4];
        logic [2:0]  r_exp;
        logic [3:0]  g_exp;
        int          rnd;
        int          ph;

        n_vec = 0;
        n_bad = 0;

        vt[0]  = '{4'b0001, 16'h0009, 16'h0005, 9'b0001_0_0_0_0_1};
        vt[1]  = '{4'b0001, 16'h0009, 16'h0005, 9'b0001_1_0_1_0_1};
        vt[2]  = '{4'b0000, 16'h0009, 16'h0005, 9'b0000_0_0_1_0_0};
        vt[3]  = '{4'b0000, 16'h0009, 16'h0005, 9'b0000_0_0_1_0_0};
        vt[4]  = '{4'b0010, 16'h0070, 16'h0070, 9'b0010_0_0_1_0_1};
        vt[5]  = '{4'b0010, 16'h0070, 16'h0070, 9'b0010_1_1_0_0_1};
        vt[6]  = '{4'b0000, 16'h0070, 16'h0070, 9'b0000_0_1_0_0_0};
        vt[7]  = '{4'b0010, 16'h0030, 16'h00C0, 9'b0000_0_1_0_0_0};
        vt[8]  = '{4'b0010, 16'h0030, 16'h00C0, 9'b0010_0_1_0_0_1};
        vt[9]  = '{4'b0010, 16'h0030, 16'h00C0, 9'b0010_1_0_0_1_1};
        vt[10] = '{4'b0000, 16'h0030, 16'h00C0, 9'b0000_0_0_0_1_0};
        vt[11] = '{4'b0000, 16'h0030, 16'h00C0, 9'b0000_0_0_0_1_0};
        vt[12] = '{4'b0100, 16'h0A00, 16'h0400, 9'b0100_0_0_0_1_1};
        vt[13] = '{4'b0100, 16'h0A00, 16'h0400, 9'b0100_1_0_1_0_1};
        vt[14] = '{4'b0100, 16'h0A00, 16'h0400, 9'b0000_0_0_1_0_0};
        vt[15] = '{4'b0100, 16'h0A00, 16'h0400, 9'b0000_0_0_1_0_0};
        vt[16] = '{4'b0100, 16'h0A00, 16'h0400, 9'b0100_0_0_1_0_1};
        vt[17] = '{4'b0000, 16'h0A00, 16'h0400, 9'b0100_1_0_1_0_1};
        vt[18] = '{4'b0000, 16'h0A00, 16'h0400, 9'b0000_0_0_1_0_0};
        vt[19] = '{4'b0000, 16'h0A00, 16'h0400, 9'b0000_0_0_1_0_0};
        vt[20] = '{4'b0001, 16'h000F, 16'h0001, 9'b0001_0_0_1_0_1};
        vt[21] = '{4'b0001, 16'h0000, 16'h0001, 9'b0001_1_0_1_0_1};
        vt[22] = '{4'b0000, 16'h0000, 16'h0001, 9'b0000_0_0_1_0_0};
        vt[23] = '{4'b0000, 16'h0000, 16'h0001, 9'b0000_0_0_1_0_0};

        rst      = 1'b1;
        bif.req  = '0;
        bif.a_in = '0;
        bif.b_in = '0;
        repeat (2) @(negedge clk);
        chk("reset", 9'b0000_0_0_0_0_0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            bif.req  = vt[i].req;
            bif.a_in = vt[i].a;
            bif.b_in = vt[i].b;
            @(negedge clk);
            chk($sformatf("vec%0d", i), vt[i].exp);
        end

        // All four requesting from reset: {c, agb, alb} per requester.
        res[0] = 3'b010;
        res[1] = 3'b100;
        res[2] = 3'b001;
        res[3] = 3'b010;
        rst = 1'b1;
        bif.req = '0;
        #1;
        chk("reset_again", 9'b0000_0_0_0_0_0);
        @(negedge clk);
        rst      = 1'b0;
        bif.req  = 4'b1111;
        bif.a_in = 16'hF379;
        bif.b_in = 16'hEC75;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            rnd   = t / 3;
            ph    = t % 3;
            g_exp = 4'b0001 << (rnd % 4);
            if (ph == 0) begin
                r_exp = (rnd == 0) ? 3'b000 : res[(rnd - 1) % 4];
                chk($sformatf("rr_t%0d", t), {g_exp, 1'b0, r_exp, 1'b1});
            end else if (ph == 1) begin
                chk($sformatf("rr_t%0d", t),
                    {g_exp, 1'b1, res[rnd % 4], 1'b1});
            end else begin
                chk($sformatf("rr_t%0d", t),
                    {4'b0000, 1'b0, res[rnd % 4], 1'b0});
            end
        end

        // Reset during CMP aborts; next search restarts at requester 0.
        bif.req = 4'b0100;
        @(negedge clk);
        chk("abort_grant", 9'b0100_0_0_1_0_1);
        rst = 1'b1;
        #1;
        chk("abort_async", 9'b0000_0_0_0_0_0);
        @(negedge clk);
        chk("abort_nodone", 9'b0000_0_0_0_0_0);
        rst     = 1'b0;
        bif.req = 4'b1001;
        @(negedge clk);
        chk("post_rst_gnt", 9'b0001_0_0_0_0_1);
        @(negedge clk);
        chk("post_rst_done", 9'b0001_1_0_1_0_1);
        bif.req = '0;
        @(negedge clk);
        chk("post_rst_idle", 9'b0000_0_0_1_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
